// File: rtl/mux_nx1_arb.sv
// N-to-1 registered channel mux with explicit-select or round-robin grant.
// Define MUX_NX1_ARB_PARITY_EN to add a registered even-parity output out_par.
module mux_nx1_arb_lane #(
  parameter int SW  = 2,
  parameter int IDX = 0
) (
  input  logic [SW-1:0] select,
  input  logic          valid,
  output logic          hit
);
  assign hit = valid && (select == SW'(IDX));
endmodule

module mux_nx1_arb #(
  parameter  int W  = 32,
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SW-1:0]  select,
  input  logic [N*W-1:0] ch_data,
  input  logic [N-1:0]   ch_valid,
  output logic [N-1:0]   ch_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
`ifdef MUX_NX1_ARB_PARITY_EN
  output logic           out_par,
`endif
  input  logic           out_ready,
  output logic [SW-1:0]  out_chan
);

  logic [N-1:0][W-1:0] ch_arr;
  logic [N-1:0]        sel_hit;
  logic                gnt_vld, load;
  logic [SW-1:0]       gnt_idx;
  logic                out_valid_q, out_valid_d;
  logic [W-1:0]        out_data_q, out_data_d;
  logic [SW-1:0]       out_chan_q, out_chan_d;
  logic [SW-1:0]       ptr_q, ptr_d;
  logic                par_q, par_d;

  assign ch_arr = ch_data;

  // Lanes never match an out-of-range select, so select>=N yields no grant.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    mux_nx1_arb_lane #(.SW(SW), .IDX(gi)) u_lane (
      .select (select),
      .valid  (ch_valid[gi]),
      .hit    (sel_hit[gi])
    );
  end

  always_comb begin
    int tmp;
    tmp     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (!mode) begin
      gnt_vld = |sel_hit;
      gnt_idx = select;
    end else begin
      // Scan backwards so the candidate closest after ptr is written last and wins.
      for (int k = N; k >= 1; k--) begin
        tmp = int'(ptr_q) + k;
        if (tmp >= N) tmp = tmp - N;
        if (ch_valid[tmp]) begin
          gnt_vld = 1'b1;
          gnt_idx = SW'(tmp);
        end
      end
    end
  end

  assign load = !out_valid_q || out_ready;

  always_comb begin
    ch_ready = '0;
    if (rst && load && gnt_vld) ch_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    par_d       = par_q;
    if (load) begin
      out_valid_d = gnt_vld;
      if (gnt_vld) begin
        out_data_d = ch_arr[gnt_idx];
        out_chan_d = gnt_idx;
        par_d      = ^ch_arr[gnt_idx];
        if (mode) ptr_d = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= SW'(N - 1);
      par_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
      par_q       <= par_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
`ifdef MUX_NX1_ARB_PARITY_EN
  assign out_par   = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_mux_nx1_arb.sv
// Randomized self-checking bench for mux_nx1_arb (W=8, N=3) against a queue-free grant model.
module tb_mux_nx1_arb;
  localparam int W = 8;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         mode;
  logic [1:0]   select;
  logic [N*W-1:0] ch_data;
  logic [N-1:0] ch_valid;
  logic [N-1:0] ch_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_chan;
`ifdef MUX_NX1_ARB_PARITY_EN
  logic         out_par;
`endif

  int checks = 0;
  int failures = 0;

  // model state
  bit       m_vld;
  bit [7:0] m_data;
  int       m_chan;
  int       m_ptr;

  mux_nx1_arb #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst), .mode(mode), .select(select),
    .ch_data(ch_data), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .out_data(out_data), .out_valid(out_valid),
`ifdef MUX_NX1_ARB_PARITY_EN
    .out_par(out_par),
`endif
    .out_ready(out_ready), .out_chan(out_chan)
  );

  always #5 clk = ~clk;

  function automatic int mdl_grant();
    if (!mode) begin
      if (int'(select) < N) begin
        if (ch_valid[select]) return int'(select);
      end
      return -1;
    end
    for (int k = 1; k <= N; k++)
      if (ch_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] mdl_ready();
    int g;
    g = mdl_grant();
    if (!rst) return '0;
    if ((!m_vld || out_ready) && g >= 0) return 3'(1 << g);
    return '0;
  endfunction

  function automatic bit [7:0] chan_word(int c);
    logic [N*W-1:0] d;
    d = ch_data;
    return d[c*W +: W];
  endfunction

  task automatic mdl_reset();
    m_vld = 0; m_data = 0; m_chan = 0; m_ptr = N - 1;
  endtask

  // Advance one clock and update the model with the inputs that were stable before the edge.
  task automatic tick();
    int g;
    bit ld;
    g  = mdl_grant();
    ld = !m_vld || out_ready;
    @(posedge clk);
    if (rst && ld) begin
      m_vld = (g >= 0);
      if (g >= 0) begin
        m_data = chan_word(g);
        m_chan = g;
        if (mode) m_ptr = g;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 0; mode = 0; select = 0; ch_data = 24'h112233; ch_valid = 3'b111; out_ready = 1;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", out_data); end
    checks++; if (out_chan !== 2'd0) begin failures++; $display("FAIL reset_chan got=%0d exp=0", out_chan); end
    checks++; if (ch_ready !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", ch_ready); end
    ch_valid = 0;
    rst = 1;
  endtask

  task automatic test_round_robin();
    int exp_seq[4] = '{0, 1, 2, 0};
    mode = 1; ch_valid = 3'b111; out_ready = 1; ch_data = 24'h332211;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_chan !== 2'(exp_seq[i]) || out_valid !== 1'b1) begin
        failures++; $display("FAIL rr_seq[%0d] got chan=%0d vld=%b exp chan=%0d vld=1", i, out_chan, out_valid, exp_seq[i]);
      end
    end
  endtask

  task automatic test_mode0();
    mode = 0; select = 1; ch_data = {8'h00, 8'hA5, 8'h00}; ch_valid = 3'b010; out_ready = 1;
    #1;
    checks++; if (ch_ready !== 3'b010) begin failures++; $display("FAIL m0_ready got=%b exp=010", ch_ready); end
    tick();
    checks++; if (out_data !== 8'hA5 || out_chan !== 2'd1 || out_valid !== 1'b1) begin
      failures++; $display("FAIL m0_out got=%h/%0d/%b exp=a5/1/1", out_data, out_chan, out_valid);
    end
  endtask

  task automatic test_out_of_range();
    select = 3; ch_valid = 3'b111; ch_data = 24'h5A5A5A;
    #1;
    checks++; if (ch_ready !== 3'b000) begin failures++; $display("FAIL oor_ready got=%b exp=000", ch_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 8'hA5) begin
      failures++; $display("FAIL oor_out got vld=%b data=%h exp vld=0 data=a5", out_valid, out_data);
    end
  endtask

  task automatic test_stall();
    mode = 0; select = 0; ch_data = {8'h00, 8'h00, 8'h3C}; ch_valid = 3'b001; out_ready = 1;
    tick();
    out_ready = 0; ch_valid = 3'b111; ch_data = {8'h77, 8'h66, 8'h55}; select = 2;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ch_ready !== 3'b000) begin failures++; $display("FAIL stall_ready[%0d] got=%b exp=000", i, ch_ready); end
      tick();
      checks++; if (out_data !== 8'h3C || out_valid !== 1'b1 || out_chan !== 2'd0) begin
        failures++; $display("FAIL stall_hold[%0d] got=%h/%b/%0d exp=3c/1/0", i, out_data, out_valid, out_chan);
      end
    end
    out_ready = 1;
    #1;
    checks++; if (ch_ready !== 3'b100) begin failures++; $display("FAIL stall_release_ready got=%b exp=100", ch_ready); end
    tick();
    checks++; if (out_data !== 8'h77 || out_chan !== 2'd2) begin
      failures++; $display("FAIL stall_release_out got=%h/%0d exp=77/2", out_data, out_chan);
    end
  endtask

  task automatic test_reset_mid();
    mode = 0; select = 1; ch_data = {8'h00, 8'h99, 8'h00}; ch_valid = 3'b010; out_ready = 0;
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre got vld=%b exp=1", out_valid); end
    #2 rst = 0;
    #1;
    mdl_reset();
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      failures++; $display("FAIL rmid_async got vld=%b data=%h exp 0/00", out_valid, out_data);
    end
    checks++; if (ch_ready !== 3'b000) begin failures++; $display("FAIL rmid_ready got=%b exp=000", ch_ready); end
    @(posedge clk); #1;
    rst = 1; mode = 1; ch_valid = 3'b111; out_ready = 1;
    tick();
    checks++; if (out_chan !== 2'd0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL rmid_first got chan=%0d vld=%b exp 0/1", out_chan, out_valid);
    end
  endtask

`ifdef MUX_NX1_ARB_PARITY_EN
  task automatic test_parity();
    mode = 0; select = 0; ch_valid = 3'b001; out_ready = 1; ch_data = {16'h0, 8'h07};
    tick();
    checks++; if (out_par !== 1'b1) begin failures++; $display("FAIL par_07 got=%b exp=1", out_par); end
    ch_data = {16'h0, 8'h03};
    tick();
    checks++; if (out_par !== 1'b0) begin failures++; $display("FAIL par_03 got=%b exp=0", out_par); end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] er;
    for (int i = 0; i < 400; i++) begin
      mode      = 1'($urandom_range(0, 1));
      select    = 2'($urandom_range(0, 3));
      ch_valid  = 3'($urandom);
      ch_data   = 24'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      er = mdl_ready();
      checks++; if (ch_ready !== er) begin failures++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, ch_ready, er); end
      tick();
      checks++; if (out_valid !== m_vld || out_data !== m_data || out_chan !== 2'(m_chan)) begin
        failures++; $display("FAIL rand_out[%0d] got=%b/%h/%0d exp=%b/%h/%0d", i, out_valid, out_data, out_chan, m_vld, m_data, m_chan);
      end
`ifdef MUX_NX1_ARB_PARITY_EN
      checks++; if (out_par !== ^m_data) begin failures++; $display("FAIL rand_par[%0d] got=%b exp=%b", i, out_par, ^m_data); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_mode0();
    test_out_of_range();
    test_stall();
    test_reset_mid();
`ifdef MUX_NX1_ARB_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mux_nx1_arb.md
MUX_NX1_ARB -- requirements
Module: mux_nx1_arb

Interface
REQ-001 SHALL have parameter W, default 32: data width per channel, 1..64.
REQ-002 SHALL have parameter N, default 4: channel count, 2..8.
REQ-003 SHALL have localparam SW = clog2(N): select/index width.
REQ-004 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port mode  input  1  grant mode: 0 = explicit select, 1 = round-robin.
REQ-007 SHALL have port select  input  SW  channel index used in mode 0.
REQ-008 SHALL have port ch_data  input  N*W  flattened channel data; channel i occupies bits [i*W +: W].
REQ-009 SHALL have port ch_valid  input  N  per-channel valid.
REQ-010 SHALL have port ch_ready  output  N  per-channel accept strobe, one-hot or zero.
REQ-011 SHALL have port out_data  output  W  registered output data.
REQ-012 SHALL have port out_valid  output  1  registered output valid.
REQ-013 SHALL have port out_ready  input  1  downstream accept.
REQ-014 SHALL have port out_chan  output  SW  index of the channel held in out_data.

Function
REQ-015 SHALL define load = !out_valid || out_ready; the output register updates only when load=1.
REQ-016 Mode 0 grant SHALL be channel select when select<N and ch_valid[select]=1; otherwise no grant.
REQ-017 Mode 1 grant SHALL be the first valid channel scanning ptr+1, ptr+2, ..., wrapping N-1->0, ending at ptr.
REQ-018 ch_ready[g] SHALL be 1 combinationally when load=1 and g is granted; all other bits SHALL be 0.
REQ-019 On load with grant g: out_data<=ch_data[g], out_chan<=g, out_valid<=1; latency is one cycle.
REQ-020 On load with no grant: out_valid<=0, and out_data and out_chan SHALL hold.
REQ-021 ptr SHALL update to g only on a mode-1 transfer; mode-0 transfers SHALL leave ptr unchanged.
REQ-022 A mode or select change SHALL take effect at the next grant evaluation; the held output SHALL NOT be disturbed.
REQ-023 With out_valid=1 and out_ready=0, ch_ready SHALL be all zero and all outputs SHALL hold (no data loss).
REQ-024 Back-to-back transfers SHALL sustain one word per cycle while out_ready=1.
REQ-025 select>=N (non-power-of-two N) SHALL behave as no grant, never as an X or aliased index.

Reset
REQ-026 rst=0 SHALL asynchronously force out_valid=0, out_data=0, out_chan=0 and ptr=N-1, so that channel 0 has first priority.
REQ-027 Reset SHALL discard an in-flight word; ch_ready SHALL be 0 while rst=0.
REQ-028 The first grant SHALL be evaluated on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro MUX_NX1_ARB_PARITY_EN defined: SHALL add output out_par (1 bit) = XOR of the W bits of out_data, registered together with out_data and reset to 0.
REQ-030 Macro MUX_NX1_ARB_PARITY_EN undefined: out_par port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (W=8, N=3)
REQ-031 Mode 0: select=1, ch_data[1]=0xA5, ch_valid=3'b010, out_ready=1 -> ch_ready=3'b010; next cycle out_data=0xA5, out_chan=1, out_valid=1.
REQ-032 Mode 0: select=3 (out of range), ch_valid=3'b111 -> ch_ready=0; next cycle out_valid=0, out_data holds.
REQ-033 Mode 1 after reset: ch_valid=3'b111 held, out_ready=1 -> out_chan sequence 0,1,2,0 on consecutive cycles.
REQ-034 Stall: out_valid=1 with 0x3C, out_ready=0 for 4 cycles, new ch_valid active -> ch_ready=0 and out_data stays 0x3C; first out_ready=1 cycle accepts the next word.
REQ-035 Reset mid-stream: rst=0 while out_valid=1 -> out_valid=0, out_data=0 immediately; after release, mode 1 grants channel 0 first.
REQ-036 With MUX_NX1_ARB_PARITY_EN defined: transfer 0x07 -> out_par=1; transfer 0x03 -> out_par=0.
